gpio_port: RTL and testbench

- Parametrised, register-mapped general-purpose I/O port; successor to the fixed 8-bit single-config port.
- Adds per-bit direction, atomic set/clear of outputs, synchronised inputs, and per-bit edge-detect interrupts with write-1-to-clear status.
- Sits on the CPU chip-select bus. Exposes pad_in/pad_out/pad_oe; tristate buffers are instantiated outside this block.

---
 rtl/gpio_bus_if.sv | 30 +++
 rtl/gpio_port.sv | 126 ++++++++++++
 tb/tb_gpio_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_if.sv
// CPU chip-select bus for gpio_port.
// Master is the CPU side, slave is the peripheral.
interface gpio_bus_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       addr;
  logic [WIDTH-1:0] data_tx;
  logic [WIDTH-1:0] data_rx;
  logic             cs_n;
  logic             oe_n;
  logic             we_n;

  modport master (
    output addr,
    output data_tx,
    output cs_n,
    output oe_n,
    output we_n,
    input  data_rx
  );

  modport slave (
    input  addr,
    input  data_tx,
    input  cs_n,
    input  oe_n,
    input  we_n,
    output data_rx
  );
endinterface

// File: rtl/gpio_port.sv
// Register-mapped GPIO port: per-bit direction, set/clear,
// synchronised inputs and edge-detect interrupts with W1C status.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bus_if.slave        bus,
  output logic             irq,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe
);

  localparam logic [2:0] A_DIR  = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_EN   = 3'd5;
  localparam logic [2:0] A_POL  = 3'd6;
  localparam logic [2:0] A_STAT = 3'd7;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_en;
  logic [WIDTH-1:0] r_pol;
  logic [WIDTH-1:0] r_stat;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_data_rx;
  logic             r_irq;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rdata;

  // Write takes priority when both strobes are low.
  assign w_wr = !bus.cs_n && !bus.we_n;
  assign w_rd = !bus.cs_n && !bus.oe_n && !w_wr;

  assign w_sync_in = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sync_in & ~r_prev;
  assign w_fall    = ~w_sync_in & r_prev;
  assign w_event   = (r_pol & w_fall) | (~r_pol & w_rise);

  assign w_w1c = (w_wr && bus.addr == A_STAT)
               ? bus.data_tx : '0;

  always_comb begin
    w_rdata = '0;
    unique case (bus.addr)
      A_DIR:  w_rdata = r_dir;
      A_OUT:  w_rdata = r_out;
      A_IN:   w_rdata = w_sync_in;
      A_SET:  w_rdata = r_out;
      A_CLR:  w_rdata = r_out;
      A_EN:   w_rdata = r_en;
      A_POL:  w_rdata = r_pol;
      A_STAT: w_rdata = r_stat;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
      r_prev <= w_sync_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir <= '0;
      r_out <= '0;
      r_en  <= '0;
      r_pol <= '0;
    end else if (w_wr) begin
      unique case (bus.addr)
        A_DIR: r_dir <= bus.data_tx;
        A_OUT: r_out <= bus.data_tx;
        A_SET: r_out <= r_out | bus.data_tx;
        A_CLR: r_out <= r_out & ~bus.data_tx;
        A_EN:  r_en  <= bus.data_tx;
        A_POL: r_pol <= bus.data_tx;
        default: ;
      endcase
    end
  end

  // A fresh event overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_stat <= (r_stat & ~w_w1c) | w_event;
      r_irq  <= |(r_stat & r_en);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_data_rx <= '0;
    else if (w_rd)
      r_data_rx <= w_rdata;
  end

  assign bus.data_rx = r_data_rx;
  assign irq         = r_irq;
  assign pad_out     = r_out;
  assign pad_oe      = r_dir;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: an 8-bit/2-stage instance
// plus a 16-bit/3-stage instance for the latency shift.
module tb_gpio_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pad8 = '0;
  logic [15:0] pad16 = '0;
  logic [7:0]  out8, oe8;
  logic [15:0] out16, oe16;
  logic        irq8, irq16;
  logic [7:0]  d8;
  logic [15:0] d16;
  int          n_chk = 0;
  int          n_err = 0;

  gpio_bus_if #(.WIDTH(8))  b8 ();
  gpio_bus_if #(.WIDTH(16)) b16 ();

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave), .irq(irq8),
    .pad_in(pad8), .pad_out(out8), .pad_oe(oe8)
  );

  gpio_port #(.WIDTH(16), .SYNC_STAGES(3)) dut16 (
    .clk(clk), .reset(reset), .bus(b16.slave), .irq(irq16),
    .pad_in(pad16), .pad_out(out16), .pad_oe(oe16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr8(input logic [2:0] a, input logic [7:0] d);
    b8.addr = a; b8.data_tx = d; b8.cs_n = 0; b8.we_n = 0;
    tick();
    b8.cs_n = 1; b8.we_n = 1;
  endtask

  task automatic rd8(input logic [2:0] a, output logic [7:0] d);
    b8.addr = a; b8.cs_n = 0; b8.oe_n = 0;
    tick();
    d = b8.data_rx;
    b8.cs_n = 1; b8.oe_n = 1;
  endtask

  task automatic wr16(input logic [2:0] a, input logic [15:0] d);
    b16.addr = a; b16.data_tx = d; b16.cs_n = 0; b16.we_n = 0;
    tick();
    b16.cs_n = 1; b16.we_n = 1;
  endtask

  task automatic rd16(input logic [2:0] a, output logic [15:0] d);
    b16.addr = a; b16.cs_n = 0; b16.oe_n = 0;
    tick();
    d = b16.data_rx;
    b16.cs_n = 1; b16.oe_n = 1;
  endtask

  initial begin
    b8.addr = '0; b8.data_tx = '0;
    b8.cs_n = 1; b8.oe_n = 1; b8.we_n = 1;
    b16.addr = '0; b16.data_tx = '0;
    b16.cs_n = 1; b16.oe_n = 1; b16.we_n = 1;
    pad8 = 8'h60;
    repeat (3) tick();
    reset = 1'b1;

    // Reset state
    chk("rst_oe8", oe8, 8'h00);
    chk("rst_out8", out8, 8'h00);
    chk("rst_irq8", irq8, 1'b0);
    chk("rst_rx8", b8.data_rx, 8'h00);
    chk("rst_oe16", oe16, 16'h0000);
    rd8(3'd7, d8); chk("rst_stat", d8, 8'h00);
    rd8(3'd0, d8); chk("rst_dir", d8, 8'h00);
    rd8(3'd1, d8); chk("rst_out", d8, 8'h00);
    rd8(3'd5, d8); chk("rst_en", d8, 8'h00);
    rd8(3'd6, d8); chk("rst_pol", d8, 8'h00);
    rd8(3'd2, d8); chk("rst_in", d8, 8'h60);
    // Pins high at release give one rising event
    rd8(3'd7, d8); chk("rel_stat", d8, 8'h60);
    wr8(3'd7, 8'hFF);
    pad8 = 8'h00;
    repeat (4) tick();
    rd8(3'd7, d8); chk("stat_clr", d8, 8'h00);

    // Direction and output set/clear
    wr8(3'd0, 8'h0F);
    wr8(3'd1, 8'hA5);
    wr8(3'd3, 8'h10);
    wr8(3'd4, 8'h01);
    chk("pad_oe", oe8, 8'h0F);
    chk("pad_out", out8, 8'hB4);
    rd8(3'd1, d8); chk("rd_out", d8, 8'hB4);
    rd8(3'd3, d8); chk("rd_set", d8, 8'hB4);

    // Rising edge interrupt on bit 0
    wr8(3'd5, 8'h01);
    wr8(3'd6, 8'h00);
    pad8[0] = 1'b1;
    repeat (3) tick();
    chk("irq_pre", irq8, 1'b0);
    tick();
    chk("irq_set", irq8, 1'b1);
    rd8(3'd7, d8); chk("stat_b0", d8, 8'h01);
    wr8(3'd7, 8'h01);
    chk("irq_w1c_e1", irq8, 1'b1);
    tick();
    chk("irq_w1c_e2", irq8, 1'b0);

    // Falling polarity on bit 3
    wr8(3'd6, 8'h08);
    pad8[3] = 1'b1;
    repeat (4) tick();
    rd8(3'd7, d8); chk("pol_rise", d8, 8'h00);
    pad8[3] = 1'b0;
    repeat (3) tick();
    rd8(3'd7, d8); chk("pol_fall", d8, 8'h08);
    chk("irq_dis", irq8, 1'b0);
    wr8(3'd5, 8'h08);
    chk("irq_en_e1", irq8, 1'b0);
    tick();
    chk("irq_en_e2", irq8, 1'b1);
    wr8(3'd7, 8'h08);
    tick();
    chk("irq_clr3", irq8, 1'b0);

    // Event beats a same-cycle W1C
    pad8[0] = 1'b0;
    repeat (3) tick();
    pad8[0] = 1'b1;
    repeat (2) tick();
    wr8(3'd7, 8'h01);
    rd8(3'd7, d8); chk("evt_wins", d8, 8'h01);
    wr8(3'd7, 8'h01);
    rd8(3'd7, d8); chk("w1c_ok", d8, 8'h00);

    // Simultaneous read and write: write only
    rd8(3'd6, d8); chk("rd_pol", d8, 8'h08);
    b8.addr = 3'd0; b8.data_tx = 8'h33;
    b8.cs_n = 0; b8.oe_n = 0; b8.we_n = 0;
    tick();
    b8.cs_n = 1; b8.oe_n = 1; b8.we_n = 1;
    chk("rw_wr", oe8, 8'h33);
    chk("rw_rx", b8.data_rx, 8'h08);

    // Asynchronous reset during a DIR write
    b8.addr = 3'd0; b8.data_tx = 8'hFF;
    b8.cs_n = 0; b8.we_n = 0;
    tick();
    chk("pre_rst", oe8, 8'hFF);
    #2 reset = 1'b0;
    #1;
    chk("async_oe", oe8, 8'h00);
    chk("async_out", out8, 8'h00);
    b8.cs_n = 1; b8.we_n = 1;
    tick();
    reset = 1'b1;
    rd8(3'd0, d8); chk("post_dir", d8, 8'h00);

    // 16-bit, 3-stage instance
    pad16 = 16'h0000;
    wr16(3'd5, 16'h0001);
    pad16[0] = 1'b1;
    repeat (4) tick();
    chk("w16_irq_pre", irq16, 1'b0);
    tick();
    chk("w16_irq", irq16, 1'b1);
    rd16(3'd7, d16); chk("w16_stat", d16, 16'h0001);
    rd16(3'd2, d16); chk("w16_in", d16, 16'h0001);
    wr16(3'd1, 16'hA5A5);
    wr16(3'd3, 16'h5A00);
    wr16(3'd4, 16'h0005);
    chk("w16_out", out16, 16'hFFA0);
    wr16(3'd0, 16'hF00F);
    chk("w16_oe", oe16, 16'hF00F);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
